// File: rtl/lbg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lbg_pkg : shared constants, FSM state type and saturating add/sub for the  |
// |           LBG codebook split block.                                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lbg_pkg;

  localparam int DIM       = 13;
  localparam int DW        = 14;
  localparam int MAX_CW    = 16;
  localparam int EPS_SHIFT = 5;
  localparam int AW        = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WHI  = 3'd2,
    S_WLO  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Overflow shows up as disagreement between the two top bits of the DW+1 result.
  function automatic logic signed [DW-1:0] sat_fix(input logic signed [DW:0] s);
    if (s[DW] != s[DW-1])
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    return sat_fix(s);
  endfunction

  function automatic logic signed [DW-1:0] sat_sub(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} - {b[DW-1], b};
    return sat_fix(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbg_cb_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lbg_cb_ram : codebook storage, one write port and one synchronous read.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lbg_cb_ram
  import lbg_pkg::*;
#(
  parameter int WIDTH  = DW,
  parameter int DEPTH  = MAX_CW * DIM,
  parameter int ADDR_W = AW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; the read register holds when i_re is low.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/lbg_codebook_split.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lbg_codebook_split : captures the mean vector as codeword 0 and doubles    |
// |                      the codebook with one LBG binary split on request.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lbg_codebook_split
  import lbg_pkg::*;
#(
  parameter int DIM       = lbg_pkg::DIM,
  parameter int DW        = lbg_pkg::DW,
  parameter int MAX_CW    = lbg_pkg::MAX_CW,
  parameter int EPS_SHIFT = lbg_pkg::EPS_SHIFT,
  parameter int AW        = lbg_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] i_init_data,
  input  logic [3:0]           i_init_addr,
  input  logic                 i_init_en,
  input  logic                 i_init_done,
  input  logic                 i_split_start,
  output logic                 o_split_busy,
  output logic                 o_split_done,
  output logic                 o_split_err,
  output logic [4:0]           o_cw_count,
  input  logic [AW-1:0]        i_rd_addr,
  output logic signed [DW-1:0] o_rd_data
);

  localparam logic [4:0] c_half   = 5'(MAX_CW / 2);
  localparam logic [3:0] c_last_d = 4'(DIM - 1);

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_k, r_d;
  logic [4:0]           r_cw_count;
  logic                 r_split_err;
  logic                 r_q_ext;
  logic signed [DW-1:0] r_rd_hold;

  logic                 w_legal, w_accept, w_last;
  logic                 w_we, w_re;
  logic [AW-1:0]        w_waddr, w_raddr, w_rd_int, w_wr_hi;
  logic signed [DW-1:0] w_wdata, w_q, w_delta;

  assign w_legal  = (r_cw_count != 5'd0) && (r_cw_count <= c_half);
  assign w_accept = (r_state == S_IDLE) && i_split_start && w_legal;
  assign w_last   = (r_k == 4'd0) && (r_d == c_last_d);
  assign w_rd_int = AW'(r_k) * AW'(DIM) + AW'(r_d);
  assign w_wr_hi  = AW'({r_k, 1'b0}) * AW'(DIM) + AW'(r_d);

  // A zero perturbation is bumped to +1 so the two children never coincide.
  always_comb begin
    w_delta = w_q >>> EPS_SHIFT;
    if (w_delta == '0) w_delta = {{(DW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The RAM read register is left untouched in WHI/WLO, so y stays on w_q for both writes.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = AW'(i_init_addr);
    w_wdata     = i_init_data;
    w_raddr     = i_rd_addr;
    case (r_state)
      S_IDLE: begin
        w_re = 1'b1;
        w_we = i_init_en;
        if (w_accept) w_state_nxt = S_RD;
      end
      S_RD: begin
        w_re        = 1'b1;
        w_raddr     = w_rd_int;
        w_state_nxt = S_WHI;
      end
      S_WHI: begin
        w_we        = 1'b1;
        w_waddr     = w_wr_hi;
        w_wdata     = sat_add(w_q, w_delta);
        w_state_nxt = S_WLO;
      end
      S_WLO: begin
        w_we        = 1'b1;
        w_waddr     = w_wr_hi + AW'(DIM);
        w_wdata     = sat_sub(w_q, w_delta);
        w_state_nxt = w_last ? S_DONE : S_RD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_d         <= '0;
      r_cw_count  <= '0;
      r_split_err <= 1'b0;
      r_q_ext     <= 1'b0;
      r_rd_hold   <= '0;
    end else begin
      r_split_err <= (r_state == S_IDLE) && i_split_start && !w_legal;
      r_q_ext     <= (r_state == S_IDLE);
      if (r_q_ext) r_rd_hold <= w_q;

      // k descends so every source word is read before its slot is overwritten.
      if (w_accept) begin
        r_k <= 4'(r_cw_count - 5'd1);
        r_d <= '0;
      end else if (r_state == S_WLO) begin
        if (r_d == c_last_d) begin
          r_d <= '0;
          r_k <= r_k - 4'd1;
        end else begin
          r_d <= r_d + 4'd1;
        end
      end

      if (r_state == S_DONE)                      r_cw_count <= r_cw_count << 1;
      else if (r_state == S_IDLE && i_init_done)  r_cw_count <= 5'd1;
    end
  end

  lbg_cb_ram #(
    .WIDTH  (DW),
    .DEPTH  (MAX_CW * DIM),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );

  assign o_split_busy = (r_state != S_IDLE);
  assign o_split_done = (r_state == S_DONE);
  assign o_split_err  = r_split_err;
  assign o_cw_count   = r_cw_count;
  assign o_rd_data    = r_q_ext ? w_q : r_rd_hold;

endmodule
`default_nettype wire
